riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
- Parametrised load/store unit between the core's execute stage and a data memory that may insert wait states.
- Replaces the single-cycle, always-ready, word-only memory path (mem_addr / data_out_to_mem / MemWE) with:
  - a valid/ready request handshake;
  - byte, halfword, word and (XLEN=64) doubleword accesses with byte enables;
  - load sign/zero extension, alignment checking, and bus-error and timeout reporting.
- The core freezes PC while `busy` is high.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT, 16, maximum cycles waited in MEM for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  core requests an access
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3: LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110; SB=000 SH=001 SW=010 SD=011
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  2  00 OK, 01 misaligned/illegal size, 10 bus error, 11 timeout
- busy  out  1  high from the accept cycle through RESP (PC stall)
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- mem_addr  out  XLEN  address aligned to XLEN/8 (low log2(XLEN/8) bits zero)
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ready  in  1  memory completes access this cycle
- mem_rdata  in  XLEN  read data, valid with mem_ready
- mem_err  in  1  bus error, sampled with mem_ready

Behaviour:
- Reset values:
  - req_ready=1 after reset (IDLE); busy=0, resp_valid=0, resp_rdata=0, resp_err=00.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; timeout counter=0.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1, busy=req_valid (combinational, so the core stalls in the accept cycle).
  - A handshake (req_valid & req_ready) latches we, funct3, addr and wdata.
  - Size check: byte always legal; half needs addr[0]=0; word needs addr[1:0]=0; double needs XLEN=64 and addr[2:0]=0.
  - Illegal funct3 is also an error: 011/110 when XLEN=32, any store funct3 >= 100, and 111 always.
  - Check fails -> RESP with err=01; no memory access is issued.
  - Check passes -> MEM with mem_* registered and valid from the next cycle.
- MEM:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ready.
  - mem_addr = latched addr with low offset bits cleared.
  - mem_be = size mask (1, 3, F, FF) shifted left by the byte offset.
  - mem_wdata = the low 8/16/32 bits replicated across all lanes.
  - mem_ready=1 -> capture data and go to RESP:
    - err = 10 if mem_err, else 00;
    - load data = mem_rdata >> (8*offset), truncated to the access size, sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU).
  - Counter increments on each MEM cycle without mem_ready. If TIMEOUT>0 and the counter reaches TIMEOUT-1 with no mem_ready:
    - mem_req drops at the next edge;
    - go to RESP with err=11.
  - The counter clears on leaving MEM.
- RESP:
  - resp_valid=1 for exactly one cycle, busy=1, req_ready=0; next state IDLE.
  - resp_rdata is forced to 0 for stores and any nonzero err.
  - resp_rdata and resp_err hold their values until the next response.
- Latency:
  - Zero-wait memory: accept at edge N, mem_req high in cycle N+1, resp_valid in cycle N+2.
  - Each wait state adds one cycle.
  - Misaligned access: resp_valid in cycle N+1.
- Back-to-back: a new request can be accepted in the cycle after RESP; there is no pipelining and at most one access is in flight.
- Reset mid-operation (any state): next edge -> IDLE, mem_req=0, no response issued, latched request discarded.
- A mem_ready seen outside MEM is ignored.

Test Plan:
- LW at addr 0x100 with mem_rdata=0xDEADBEEF, mem_ready in the first MEM cycle -> mem_addr=0x100, mem_be=0xF, mem_we=0; resp_valid exactly 2 cycles after accept; resp_rdata=0xDEADBEEF, err=00.
- LB at 0x103 and LBU at 0x103 with mem_rdata=0x80FF1234 -> mem_be=0x8; resp_rdata=0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH at 0x202 with req_wdata=0x0000ABCD, mem_ready held low 3 cycles -> mem_be=0xC and mem_wdata=0xABCDABCD, both stable all 4 MEM cycles; resp after 5 cycles with rdata=0, err=00.
- LW at 0x101 and SW at 0x102 -> mem_req never asserted; resp_valid 1 cycle after accept with err=01. XLEN=32 with funct3=011 -> err=01.
- TIMEOUT=4 with mem_ready stuck low -> mem_req high for exactly 4 cycles, then resp with err=11, rdata=0. Separately, mem_ready=1 with mem_err=1 -> err=10.
- Reset asserted in the 2nd MEM cycle -> next cycle mem_req=0, req_ready=1, no resp_valid. XLEN=64: LD at 0x08 with rdata=0x1122334455667788 -> be=0xFF and rdata returned unchanged.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// slave = the LSU itself; master = its surroundings (core plus data memory).
interface riscv_lsu_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [1:0]        resp_err;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rdata, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rdata, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: valid/ready core requests to a wait-state data memory with
// byte enables, load extension, alignment check, bus-error and timeout reporting.
//
// state  | meaning
// IDLE   | ready for a request; busy follows req_valid
// MEM    | memory access outstanding, mem_* held until mem_ready or timeout
// RESP   | one-cycle response pulse, then back to IDLE
module riscv_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  riscv_lsu_if.slave   bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;

  logic              req_bad;
  logic [NB-1:0]     be_mask;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   ld_shift, ld_mask, ld_ext;
  logic              ld_sign;

  // Request legality and store lane formatting, evaluated on the raw request.
  always_comb begin
    req_bad = (bus.req_funct3 == 3'b111) ||
              (bus.req_we && bus.req_funct3[2]) ||
              ((XLEN == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)));
    be_mask   = NB'(8'h01);
    wdata_rep = {NB{bus.req_wdata[7:0]}};
    case (bus.req_funct3[1:0])
      2'd1: begin
        req_bad   = req_bad || bus.req_addr[0];
        be_mask   = NB'(8'h03);
        wdata_rep = {(NB/2){bus.req_wdata[15:0]}};
      end
      2'd2: begin
        req_bad   = req_bad || (|bus.req_addr[1:0]);
        be_mask   = NB'(8'h0F);
        wdata_rep = {(NB/4){bus.req_wdata[31:0]}};
      end
      2'd3: begin
        req_bad   = req_bad || (|bus.req_addr[2:0]);
        be_mask   = NB'(8'hFF);
        wdata_rep = bus.req_wdata;
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    ld_mask  = '1;
    ld_sign  = ld_shift[XLEN-1];
    case (funct3_q[1:0])
      2'd0: begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_shift[7];  end
      2'd1: begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_shift[15]; end
      2'd2: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: ;
    endcase
    ld_ext = ld_shift & ld_mask;
    if (!funct3_q[2] && ld_sign) ld_ext = ld_ext | ~ld_mask;
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          off_d    = bus.req_addr[OFFW-1:0];
          if (req_bad) begin
            state_d      = S_RESP;
            resp_err_d   = 2'b01;
            resp_rdata_d = '0;
          end else begin
            state_d     = S_MEM;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            mem_be_d    = be_mask << bus.req_addr[OFFW-1:0];
            mem_wdata_d = wdata_rep;
          end
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d      = S_RESP;
          cnt_d        = '0;
          resp_err_d   = bus.mem_err ? 2'b10 : 2'b00;
          resp_rdata_d = (we_q || bus.mem_err) ? '0 : ld_ext;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d      = S_RESP;
          cnt_d        = '0;
          resp_err_d   = 2'b11;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE) || bus.req_valid;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = (state_q == S_MEM);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a 32-bit instance with TIMEOUT=4 and a 64-bit
// instance with the default timeout, both checked against hand-computed values.
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic rst32 = 1'b1;
  logic rst64 = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  riscv_lsu_if #(.XLEN(32)) b32 ();
  riscv_lsu_if #(.XLEN(64)) b64 ();

  riscv_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (.clk(clk), .reset(rst32), .bus(b32));
  riscv_lsu #(.XLEN(64), .TIMEOUT(16)) dut64 (.clk(clk), .reset(rst64), .bus(b64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the accept edge.
  task automatic issue32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    b32.req_valid = 1'b1; b32.req_we = we; b32.req_funct3 = f3;
    b32.req_addr = addr; b32.req_wdata = wdata;
    #1;
    chk("busy_in_accept", b32.busy, 1);
    cyc();
    b32.req_valid = 1'b0;
  endtask

  task automatic issue64(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata);
    b64.req_valid = 1'b1; b64.req_we = we; b64.req_funct3 = f3;
    b64.req_addr = addr; b64.req_wdata = wdata;
    cyc();
    b64.req_valid = 1'b0;
  endtask

  initial begin
    b32.req_valid = 0; b32.req_we = 0; b32.req_funct3 = 0; b32.req_addr = 0; b32.req_wdata = 0;
    b32.mem_ready = 0; b32.mem_rdata = 0; b32.mem_err = 0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_funct3 = 0; b64.req_addr = 0; b64.req_wdata = 0;
    b64.mem_ready = 0; b64.mem_rdata = 0; b64.mem_err = 0;
    cyc(); cyc();

    chk("rst_req_ready", b32.req_ready, 1);
    chk("rst_busy", b32.busy, 0);
    chk("rst_resp_valid", b32.resp_valid, 0);
    chk("rst_resp_rdata", b32.resp_rdata, 0);
    chk("rst_resp_err", b32.resp_err, 0);
    chk("rst_mem_req", b32.mem_req, 0);
    chk("rst_mem_we", b32.mem_we, 0);
    chk("rst_mem_addr", b32.mem_addr, 0);
    chk("rst_mem_be", b32.mem_be, 0);
    chk("rst_mem_wdata", b32.mem_wdata, 0);
    rst32 = 0; rst64 = 0;
    cyc();

    // LW 0x100, zero wait
    issue32(0, 3'b010, 32'h100, 0);
    chk("lw_mem_req", b32.mem_req, 1);
    chk("lw_mem_addr", b32.mem_addr, 32'h100);
    chk("lw_mem_be", b32.mem_be, 4'hF);
    chk("lw_mem_we", b32.mem_we, 0);
    chk("lw_req_ready_mem", b32.req_ready, 0);
    chk("lw_no_early_resp", b32.resp_valid, 0);
    b32.mem_ready = 1; b32.mem_rdata = 32'hDEADBEEF;
    cyc();
    b32.mem_ready = 0;
    chk("lw_resp_valid", b32.resp_valid, 1);
    chk("lw_rdata", b32.resp_rdata, 32'hDEADBEEF);
    chk("lw_err", b32.resp_err, 2'b00);
    chk("lw_resp_busy", b32.busy, 1);
    chk("lw_mem_req_off", b32.mem_req, 0);
    cyc();
    chk("lw_pulse_one", b32.resp_valid, 0);
    chk("lw_rdata_hold", b32.resp_rdata, 32'hDEADBEEF);
    chk("lw_ready_back", b32.req_ready, 1);

    // LB / LBU 0x103, back-to-back
    issue32(0, 3'b000, 32'h103, 0);
    chk("lb_mem_be", b32.mem_be, 4'h8);
    chk("lb_mem_addr", b32.mem_addr, 32'h100);
    b32.mem_ready = 1; b32.mem_rdata = 32'h80FF1234;
    cyc();
    b32.mem_ready = 0;
    chk("lb_rdata", b32.resp_rdata, 32'hFFFFFF80);
    cyc();
    issue32(0, 3'b100, 32'h103, 0);
    chk("lbu_mem_be", b32.mem_be, 4'h8);
    b32.mem_ready = 1;
    cyc();
    b32.mem_ready = 0;
    chk("lbu_rdata", b32.resp_rdata, 32'h00000080);
    chk("lbu_err", b32.resp_err, 2'b00);
    cyc();

    // LH 0x102 signed upper half
    issue32(0, 3'b001, 32'h102, 0);
    chk("lh_mem_be", b32.mem_be, 4'hC);
    b32.mem_ready = 1; b32.mem_rdata = 32'h9ABC0000;
    cyc();
    b32.mem_ready = 0;
    chk("lh_rdata", b32.resp_rdata, 32'hFFFF9ABC);
    cyc();

    // Timeout with TIMEOUT=4
    issue32(0, 3'b010, 32'h300, 0);
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req_high", b32.mem_req, 1);
      chk("to_no_resp", b32.resp_valid, 0);
      cyc();
    end
    chk("to_mem_req_drop", b32.mem_req, 0);
    chk("to_resp_valid", b32.resp_valid, 1);
    chk("to_err", b32.resp_err, 2'b11);
    chk("to_rdata", b32.resp_rdata, 0);
    cyc();

    // SH 0x202 with three wait states
    issue32(1, 3'b001, 32'h202, 32'h0000ABCD);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) b32.mem_ready = 1;
      chk("sh_mem_req", b32.mem_req, 1);
      chk("sh_mem_we", b32.mem_we, 1);
      chk("sh_mem_addr", b32.mem_addr, 32'h200);
      chk("sh_mem_be", b32.mem_be, 4'hC);
      chk("sh_mem_wdata", b32.mem_wdata, 32'hABCDABCD);
      chk("sh_no_resp", b32.resp_valid, 0);
      cyc();
    end
    b32.mem_ready = 0;
    chk("sh_resp_valid", b32.resp_valid, 1);
    chk("sh_rdata", b32.resp_rdata, 0);
    chk("sh_err", b32.resp_err, 2'b00);
    cyc();

    // Bus error
    issue32(0, 3'b010, 32'h104, 0);
    b32.mem_ready = 1; b32.mem_err = 1; b32.mem_rdata = 32'h12345678;
    cyc();
    b32.mem_ready = 0; b32.mem_err = 0;
    chk("berr_resp_valid", b32.resp_valid, 1);
    chk("berr_err", b32.resp_err, 2'b10);
    chk("berr_rdata", b32.resp_rdata, 0);
    cyc();

    // Misaligned / illegal requests: response one cycle after accept, no mem_req
    issue32(0, 3'b010, 32'h101, 0);
    chk("mis_lw_resp", b32.resp_valid, 1);
    chk("mis_lw_err", b32.resp_err, 2'b01);
    chk("mis_lw_mem_req", b32.mem_req, 0);
    cyc();
    issue32(1, 3'b010, 32'h102, 32'h5);
    chk("mis_sw_resp", b32.resp_valid, 1);
    chk("mis_sw_err", b32.resp_err, 2'b01);
    chk("mis_sw_mem_req", b32.mem_req, 0);
    cyc();
    issue32(0, 3'b011, 32'h0, 0);
    chk("ld32_err", b32.resp_err, 2'b01);
    chk("ld32_resp", b32.resp_valid, 1);
    cyc();
    issue32(1, 3'b100, 32'h0, 0);
    chk("st_f3_4_err", b32.resp_err, 2'b01);
    cyc();
    issue32(0, 3'b111, 32'h0, 0);
    chk("f3_7_err", b32.resp_err, 2'b01);
    cyc();

    // Reset in the second MEM cycle
    issue32(0, 3'b010, 32'h400, 0);
    chk("rmid_mem_req1", b32.mem_req, 1);
    cyc();
    chk("rmid_mem_req2", b32.mem_req, 1);
    rst32 = 1;
    cyc();
    rst32 = 0;
    chk("rmid_mem_req_off", b32.mem_req, 0);
    chk("rmid_req_ready", b32.req_ready, 1);
    chk("rmid_no_resp", b32.resp_valid, 0);
    b32.mem_ready = 1;
    cyc();
    b32.mem_ready = 0;
    chk("rmid_no_resp_later", b32.resp_valid, 0);
    chk("rmid_idle_ready_ignored", b32.req_ready, 1);
    cyc();

    // XLEN=64 instance
    issue64(0, 3'b011, 64'h08, 0);
    chk("ld_mem_addr", b64.mem_addr, 64'h08);
    chk("ld_mem_be", b64.mem_be, 8'hFF);
    b64.mem_ready = 1; b64.mem_rdata = 64'h1122334455667788;
    cyc();
    b64.mem_ready = 0;
    chk("ld_resp_valid", b64.resp_valid, 1);
    chk("ld_rdata", b64.resp_rdata, 64'h1122334455667788);
    cyc();
    issue64(0, 3'b010, 64'h0C, 0);
    chk("lw64_mem_be", b64.mem_be, 8'hF0);
    b64.mem_ready = 1; b64.mem_rdata = 64'h80000000_00000000;
    cyc();
    b64.mem_ready = 0;
    chk("lw64_rdata", b64.resp_rdata, 64'hFFFFFFFF_80000000);
    cyc();
    issue64(0, 3'b110, 64'h0C, 0);
    b64.mem_ready = 1;
    cyc();
    b64.mem_ready = 0;
    chk("lwu64_rdata", b64.resp_rdata, 64'h00000000_80000000);
    cyc();
    issue64(1, 3'b000, 64'h05, 64'hA5);
    chk("sb64_mem_be", b64.mem_be, 8'h20);
    chk("sb64_mem_wdata", b64.mem_wdata, 64'hA5A5A5A5A5A5A5A5);
    chk("sb64_mem_addr", b64.mem_addr, 64'h0);
    b64.mem_ready = 1;
    cyc();
    b64.mem_ready = 0;
    chk("sb64_rdata", b64.resp_rdata, 0);
    cyc();
    issue64(0, 3'b011, 64'h04, 0);
    chk("mis_ld64_err", b64.resp_err, 2'b01);
    chk("mis_ld64_mem_req", b64.mem_req, 0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
